// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin arbiter around a registered bitwise logic unit
// Optional build macro LOGIC_ARB_ERR_EN adds the rsp_err output flagging illegal op code 7.
module logic_unit_arbiter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef LOGIC_ARB_ERR_EN
  ,
  output logic             rsp_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  state_e           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_data_d;
  logic             busy_q;
  logic             grant1_d;
  logic             any_valid_d;
  logic             idle_d;

  always_comb begin
    any_valid_d = req0_valid | req1_valid;
    grant1_d    = req1_valid & (~req0_valid | ~last_grant_q);
    // Ready is gated by rst_n so it stays low while reset is held even with state at IDLE.
    idle_d      = rst_n & (state_q == S_IDLE);
  end

  assign req0_ready = idle_d & req0_valid & ~grant1_d;
  assign req1_ready = idle_d & grant1_d;

  always_comb begin
    rsp_data_d = '0;
    case (op_q)
      OP_AND:  rsp_data_d = a_q & b_q;
      OP_OR:   rsp_data_d = a_q | b_q;
      OP_NOT:  rsp_data_d = ~a_q;
      OP_NAND: rsp_data_d = ~(a_q & b_q);
      OP_NOR:  rsp_data_d = ~(a_q | b_q);
      OP_XOR:  rsp_data_d = a_q ^ b_q;
      OP_XNOR: rsp_data_d = ~(a_q ^ b_q);
      default: rsp_data_d = '0;
    endcase
  end

`ifdef LOGIC_ARB_ERR_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_err_q <= (op_q == OP_ILL);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid_d) begin
            op_q         <= grant1_d ? req1_op : req0_op;
            a_q          <= grant1_d ? req1_a  : req0_a;
            b_q          <= grant1_d ? req1_b  : req0_b;
            id_q         <= grant1_d;
            last_grant_q <= grant1_d;
            busy_q       <= 1'b1;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data_q  <= rsp_data_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter with a transaction-level reference model
module tb_logic_unit_arbiter;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef LOGIC_ARB_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

`ifndef LOGIC_ARB_ERR_EN
  assign rsp_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, response visible two cycles after acceptance.
  bit           m_pending;
  int           m_age;
  bit           m_last;
  bit           m_id;
  logic [W-1:0] m_data;
  bit           m_err;

  bit           hs0, hs1, saw_rsp, saw_id, saw_err;
  logic [W-1:0] saw_data;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_age     = 0;
    m_last    = 1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_data", {25'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
  endtask

  task automatic step();
    bit e_r0, e_r1, e_rv;
    logic [2:0] op;
    @(negedge clk);
    #1;
    e_r0 = !m_pending && req0_valid && (!req1_valid || m_last);
    e_r1 = !m_pending && req1_valid && (!req0_valid || !m_last);
    e_rv = m_pending && (m_age >= 2);
    chk("ready0", {31'd0, req0_ready}, {31'd0, e_r0});
    chk("ready1", {31'd0, req1_ready}, {31'd0, e_r1});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv});
    chk("busy", {31'd0, busy}, {31'd0, m_pending});
    if (e_rv) begin
      chk("rsp_data", {25'd0, rsp_data}, {25'd0, m_data});
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
`ifdef LOGIC_ARB_ERR_EN
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
`endif
    end
    saw_rsp  = rsp_valid;
    saw_data = rsp_data;
    saw_id   = rsp_id;
    saw_err  = rsp_err;
    hs0      = e_r0;
    hs1      = e_r1;
    if (e_rv && rsp_ready) m_pending = 0;
    else if (m_pending) m_age++;
    if (e_r0 || e_r1) begin
      op        = e_r1 ? req1_op : req0_op;
      m_pending = 1;
      m_age     = 1;
      m_last    = e_r1;
      m_id      = e_r1;
      m_data    = e_r1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
      m_err     = (op == 3'd7);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
    bit found;
    int lat;
    rsp_ready = 1;
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req0_valid = 0;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req1_valid = 0;
    end
    step();
    chk({tag, "_hs"}, {31'd0, (id ? hs1 : hs0)}, 32'd1);
    req0_valid = 0;
    req1_valid = 0;
    found = 0;
    lat   = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      lat++;
      if (saw_rsp) begin
        found = 1;
        break;
      end
    end
    chk({tag, "_found"}, {31'd0, found}, 32'd1);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_data"}, {25'd0, saw_data}, {25'd0, exp});
    chk({tag, "_id"}, {31'd0, saw_id}, {31'd0, id});
  endtask

  initial begin
    int g[$];
    logic [W-1:0] hold_data;
    bit hold_id;

    rst_n = 0; rsp_ready = 0;
    req0_valid = 1; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 1; req1_op = 0; req1_a = 0; req1_b = 0;
    model_reset();
    #12;
    chk_reset_outputs();
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;

    // Reset while a transaction is in EXEC: no response may ever appear.
    req0_valid = 1; req0_op = 3'd0; req0_a = 7'h55; req0_b = 7'h0F;
    step();
    chk("mid_hs", {31'd0, hs0}, 32'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_reset_outputs();
    model_reset();
    req0_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    rsp_ready = 1;
    repeat (4) step();

    run_one(0, 3'd5, 7'h55, 7'h0F, 7'h5A, "xor");
    run_one(0, 3'd2, 7'h00, 7'h7F, 7'h7F, "not");
    run_one(1, 3'd6, 7'h33, 7'h0F, 7'h43, "xnor");

    // Both requesters continuously valid: grants alternate, one per three cycles.
    req0_valid = 1; req0_op = 3'd1; req0_a = 7'h11; req0_b = 7'h22;
    req1_valid = 1; req1_op = 3'd3; req1_a = 7'h7E; req1_b = 7'h3C;
    rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (hs0) g.push_back(0);
      if (hs1) g.push_back(1);
    end
    chk("rr_count", g.size(), 32'd4);
    for (int i = 1; i < g.size(); i++) chk("rr_alt", (g[i] != g[i-1]), 32'd1);
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // Response back-pressure: output held, no new grant while both requesters wait.
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd3; req0_a = 7'h6A; req0_b = 7'h5C;
    step();
    req1_valid = 1; req1_op = 3'd4; req1_a = 7'h01; req1_b = 7'h02;
    step();
    step();
    chk("stall_valid", {31'd0, saw_rsp}, 32'd1);
    hold_data = saw_data;
    hold_id   = saw_id;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", {25'd0, saw_data}, {25'd0, hold_data});
      chk("stall_id", {31'd0, saw_id}, {31'd0, hold_id});
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_noready", {30'd0, hs0, hs1}, 32'd0);
    end
    chk("stall_value", {25'd0, hold_data}, {25'd0, ~(7'h6A & 7'h5C)});
    rsp_ready = 1;
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    run_one(0, 3'd7, 7'h7F, 7'h7F, 7'h00, "ill");
`ifdef LOGIC_ARB_ERR_EN
    chk("ill_err", {31'd0, saw_err}, 32'd1);
`endif
    run_one(1, 3'd1, 7'h40, 7'h01, 7'h41, "or");
`ifdef LOGIC_ARB_ERR_EN
    chk("or_err", {31'd0, saw_err}, 32'd0);
`endif

    // Randomized traffic, honouring payload stability while valid is pending.
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
      if (hs0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 1);
        req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        req0_valid = 0;
      end
      if (hs1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 1);
        req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        req1_valid = 0;
      end
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
